pll_lock_monitor: RTL and testbench

Supervises the ECP5 EHXPLLL that generates the 480p pixel and half-rate TMDS clocks. Runs on the free-running 25 MHz board clock and synchronizes the asynchronous PLL LOCK signal. It drives the PLL RST pin, with automatic retry on lock timeout, and holds the downstream display reset until lock has been stable long enough. Lock-loss and retry events are counted for debug LEDs and status registers.

---
 rtl/pll_mon_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 28 ++
 rtl/pll_lock_monitor.sv | 97 +++++++++
 tb/tb_pll_lock_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// Shared types and defaults for the PLL lock supervisor: state encoding,
// default cycle budgets and the sizing helper for the shared cycle timer.
package pll_mon_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    localparam int DEF_SETTLE_CYCLES  = 1024;
    localparam int DEF_TIMEOUT_CYCLES = 250000;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_CNT_W          = 8;

    // Wide enough to hold (largest budget - 1); never narrower than one bit.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m <= 1) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level signals.
// Latency 2 cycles of i_clk; no flow control, output follows input.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_dat;
            r_sync <= r_meta;
        end
    end

    assign o_dat = r_sync;

endmodule

// File: rtl/pll_lock_monitor.sv
// Supervises PLL reset/lock: pulses pll_rst, retries on lock timeout, holds sys_rst until lock is stable.
// Lock seen 2 cycles after pll_lock via synchronizer; all outputs are registered Moore decodes of the state.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk_25m,
    input  logic             rst_n,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count,
    output logic [2:0]       state_dbg
);

    localparam int TW = timer_width(SETTLE_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES, HOLD_CYCLES);
    localparam logic [TW-1:0] C_RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] C_SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] C_HOLD_LAST    = TW'(HOLD_CYCLES - 1);

    logic             w_lock_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_loss_cnt;
    logic [CNT_W-1:0] r_retry_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .i_clk   (clk_25m),
        .i_rst_n (rst_n),
        .i_dat   (pll_lock),
        .o_dat   (w_lock_s)
    );

    // A lock arriving on the timeout cycle takes priority over the retry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PLL_RESET: if (r_timer == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (w_lock_s)                        w_state_nxt = ST_SETTLE;
                else if (r_timer == C_TIMEOUT_LAST)  w_state_nxt = ST_PLL_RESET;
            end
            ST_SETTLE: begin
                if (!w_lock_s)                       w_state_nxt = ST_WAIT_LOCK;
                else if (r_timer == C_SETTLE_LAST)   w_state_nxt = ST_RUN;
            end
            ST_RUN:       if (!w_lock_s) w_state_nxt = ST_HOLD;
            ST_HOLD:      if (r_timer == C_HOLD_LAST) w_state_nxt = ST_WAIT_LOCK;
            default:      w_state_nxt = ST_PLL_RESET;
        endcase
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_PLL_RESET;
            r_timer     <= '0;
            r_loss_cnt  <= '0;
            r_retry_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
            r_pll_rst <= (w_state_nxt == ST_PLL_RESET);
            r_sys_rst <= (w_state_nxt != ST_RUN);
            r_ready   <= (w_state_nxt == ST_RUN);
            if (r_state == ST_WAIT_LOCK && w_state_nxt == ST_PLL_RESET && r_retry_cnt != '1)
                r_retry_cnt <= r_retry_cnt + 1'b1;
            if (r_state == ST_RUN && w_state_nxt == ST_HOLD && r_loss_cnt != '1)
                r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign pll_rst     = r_pll_rst;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign loss_count  = r_loss_cnt;
    assign retry_count = r_retry_cnt;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor with small cycle budgets.
// Rows of {lock input, cycles to run, expected outputs} feed a scoreboard queue.
module tb_pll_lock_monitor;

    localparam logic [2:0] S_PRST = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_SETL = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic       clk_25m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] loss_count;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    pll_lock_monitor #(
        .SETTLE_CYCLES  (8),
        .TIMEOUT_CYCLES (32),
        .PLL_RST_CYCLES (4),
        .HOLD_CYCLES    (4),
        .CNT_W          (2)
    ) dut (
        .clk_25m     (clk_25m),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .loss_count  (loss_count),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk_25m = ~clk_25m;

    typedef struct {
        string      name;
        int         n;
        logic       lock;
        logic [2:0] st;
        logic [1:0] loss;
        logic [1:0] retry;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic [1:0] loss;
        logic [1:0] retry;
    } obs_t;

    vec_t  vq[$];
    obs_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic obs_t expect_of(input logic [2:0] st, input logic [1:0] loss, input logic [1:0] retry);
        obs_t o;
        o.st    = st;
        o.prst  = (st == S_PRST);
        o.srst  = (st != S_RUN);
        o.rdy   = (st == S_RUN);
        o.loss  = loss;
        o.retry = retry;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {state_dbg, pll_rst, sys_rst, ready, loss_count, retry_count};
        return o;
    endfunction

    task automatic add(input string nm, input int n, input logic lk,
                       input logic [2:0] st, input logic [1:0] loss, input logic [1:0] retry);
        vec_t v;
        v.name = nm; v.n = n; v.lock = lk; v.st = st; v.loss = loss; v.retry = retry;
        vq.push_back(v);
    endtask

    task automatic compare_next();
        obs_t  e;
        obs_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = observe();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got st=%0d pll_rst=%b sys_rst=%b ready=%b loss=%0d retry=%0d, want st=%0d pll_rst=%b sys_rst=%b ready=%b loss=%0d retry=%0d",
                     nm, a.st, a.prst, a.srst, a.rdy, a.loss, a.retry,
                     e.st, e.prst, e.srst, e.rdy, e.loss, e.retry);
        end
    endtask

    task automatic run_rows();
        vec_t v;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            pll_lock = v.lock;
            exp_q.push_back(expect_of(v.st, v.loss, v.retry));
            name_q.push_back(v.name);
            repeat (v.n) begin
                @(posedge clk_25m);
                #1;
            end
            compare_next();
        end
    endtask

    // Leaves the bench 1 time unit after an edge with rst_n released: that point is cycle 0.
    task automatic do_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(posedge clk_25m);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos;

        // Clean start, then a one-cycle lock drop while running.
        do_reset();
        add("rst_state",     0, 1'b0, S_PRST, 2'd0, 2'd0);
        add("prst_pulse",    3, 1'b0, S_PRST, 2'd0, 2'd0);
        add("wait_enter",    1, 1'b0, S_WAIT, 2'd0, 2'd0);
        add("wait_idle",     6, 1'b0, S_WAIT, 2'd0, 2'd0);
        add("lock_sync",     2, 1'b1, S_WAIT, 2'd0, 2'd0);
        add("settle_enter",  1, 1'b1, S_SETL, 2'd0, 2'd0);
        add("settle_last",   7, 1'b1, S_SETL, 2'd0, 2'd0);
        add("run_enter",     1, 1'b1, S_RUN,  2'd0, 2'd0);
        add("run_steady",    5, 1'b1, S_RUN,  2'd0, 2'd0);
        add("drop_lock",     1, 1'b0, S_RUN,  2'd0, 2'd0);
        add("drop_sync",     1, 1'b1, S_RUN,  2'd0, 2'd0);
        add("hold_enter",    1, 1'b1, S_HOLD, 2'd1, 2'd0);
        add("hold_last",     3, 1'b1, S_HOLD, 2'd1, 2'd0);
        add("hold_exit",     1, 1'b1, S_WAIT, 2'd1, 2'd0);
        add("resettle",      1, 1'b1, S_SETL, 2'd1, 2'd0);
        add("resettle_last", 7, 1'b1, S_SETL, 2'd1, 2'd0);
        add("rerun",         1, 1'b1, S_RUN,  2'd1, 2'd0);
        run_rows();

        // Repeated timeouts with lock low; retry count saturates at 3.
        do_reset();
        add("rst_state2", 0, 1'b0, S_PRST, 2'd0, 2'd0);
        pos = 0;
        for (int k = 1; k <= 4; k++) begin
            add($sformatf("timeout%0d_pre", k),  36*k - 1 - pos, 1'b0, S_WAIT, 2'd0, 2'((k - 1 > 3) ? 3 : k - 1));
            add($sformatf("timeout%0d_prst", k), 1, 1'b0, S_PRST, 2'd0, 2'((k > 3) ? 3 : k));
            add($sformatf("timeout%0d_plast", k), 3, 1'b0, S_PRST, 2'd0, 2'((k > 3) ? 3 : k));
            add($sformatf("timeout%0d_wait", k), 1, 1'b0, S_WAIT, 2'd0, 2'((k > 3) ? 3 : k));
            pos = 36*k + 4;
        end
        add("late_lock_sync", 2, 1'b1, S_WAIT, 2'd0, 2'd3);
        add("late_settle",    1, 1'b1, S_SETL, 2'd0, 2'd3);
        add("mid_settle",     3, 1'b1, S_SETL, 2'd0, 2'd3);
        run_rows();

        // Asynchronous reset between clock edges, mid-SETTLE.
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(expect_of(S_PRST, 2'd0, 2'd0));
        name_q.push_back("async_rst");
        compare_next();
        add("rst_held", 2, 1'b1, S_PRST, 2'd0, 2'd0);
        run_rows();

        // Lock glitch during SETTLE restarts the settle window.
        do_reset();
        add("rst_state3",    0, 1'b0, S_PRST, 2'd0, 2'd0);
        add("g_wait",       10, 1'b0, S_WAIT, 2'd0, 2'd0);
        add("g_settle",      5, 1'b1, S_SETL, 2'd0, 2'd0);
        add("g_low_in",      1, 1'b0, S_SETL, 2'd0, 2'd0);
        add("g_low_sync",    1, 1'b1, S_SETL, 2'd0, 2'd0);
        add("g_back_wait",   1, 1'b1, S_WAIT, 2'd0, 2'd0);
        add("g_resettle",    1, 1'b1, S_SETL, 2'd0, 2'd0);
        add("g_settle_last", 7, 1'b1, S_SETL, 2'd0, 2'd0);
        add("g_run",         1, 1'b1, S_RUN,  2'd0, 2'd0);
        add("g_run_steady",  3, 1'b1, S_RUN,  2'd0, 2'd0);
        run_rows();

        // Synchronized lock rises exactly on the last WAIT_LOCK cycle.
        do_reset();
        add("rst_state4",    0, 1'b0, S_PRST, 2'd0, 2'd0);
        add("to_wait",      33, 1'b0, S_WAIT, 2'd0, 2'd0);
        add("to_lock_edge",  2, 1'b1, S_WAIT, 2'd0, 2'd0);
        add("to_lock_wins",  1, 1'b1, S_SETL, 2'd0, 2'd0);
        add("to_run",        8, 1'b1, S_RUN,  2'd0, 2'd0);
        run_rows();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
